// File: rtl/multi_clk_divider.sv
// Bank of independent programmable clock dividers on one 100 MHz clock.
// Each channel runs in toggle (50% clock) or pulse (strobe) mode; new settings apply glitch-free at the channel's wrap.
module multi_clk_divider #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 27,
  parameter int CH_W        = 2,
  parameter int DEFAULT_DIV = 49999
) (
  input  logic              clk_100mega,
  input  logic              rst,
  input  logic              sync_all,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              cfg_mode,
  input  logic              cfg_en,
  output logic              cfg_ack,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  typedef struct packed {
    logic [CNT_W-1:0] div;
    logic             mode;  // 0 = toggle, 1 = pulse
    logic             en;
  } cfg_t;

  localparam cfg_t RESET_CFG = '{div: CNT_W'(DEFAULT_DIV), mode: 1'b0, en: 1'b1};

  logic in_range;
  assign in_range = (32'(cfg_ch) < 32'(NUM_CH));

  // NOTE: reset here is synchronous, so it lives inside the clocked branch rather than in the sensitivity list.
  always_ff @(posedge clk_100mega) begin
    if (rst) begin
      cfg_ack <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      cfg_ack <= cfg_we && in_range;
      cfg_err <= cfg_we && !in_range;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    cfg_t             act_q;
    cfg_t             shd_q;
    logic             pend_q;
    logic [CNT_W-1:0] cnt_q;
    logic             clk_q;
    logic             tick_q;
    logic             wr;
    logic             wrap;
    logic             apply;

    assign wr    = cfg_we && in_range && (cfg_ch == CH_W'(i));
    assign wrap  = act_q.en && (cnt_q == act_q.div);
    // A disabled channel has no phase to protect, so pending settings land at once.
    assign apply = pend_q && (sync_all || !act_q.en || wrap);

    // NOTE: the shadow set has no reset; it is only read while pend_q is set, and pend_q is reset.
    always_ff @(posedge clk_100mega) begin
      if (wr) shd_q <= '{div: cfg_div, mode: cfg_mode, en: cfg_en};
    end

    always_ff @(posedge clk_100mega) begin
      if (rst) begin
        act_q  <= RESET_CFG;
        pend_q <= 1'b0;
        cnt_q  <= '0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        if (apply) act_q <= shd_q;

        // A write coincident with an apply re-arms the flag: the new shadow waits for a later wrap.
        if (wr)         pend_q <= 1'b1;
        else if (apply) pend_q <= 1'b0;

        if (sync_all || !act_q.en) begin
          cnt_q  <= '0;
          clk_q  <= 1'b0;
          tick_q <= 1'b0;
        end else if (wrap) begin
          cnt_q  <= '0;
          tick_q <= 1'b1;
          clk_q  <= act_q.mode | ~clk_q;
        end else begin
          cnt_q  <= cnt_q + 1'b1;
          tick_q <= 1'b0;
          clk_q  <= clk_q & ~act_q.mode;
        end
      end
    end

    assign clk_out[i] = clk_q;
    assign tick[i]    = tick_q;
  end

endmodule

// File: tb/tb_multi_clk_divider.sv
// Bench for multi_clk_divider: directed scenarios plus random traffic, scored every cycle
// against an elapsed-time model of each channel (two instances: 4 channels, and 3 channels to reach cfg_err).
module tb_multi_clk_divider;

  logic        clk_100mega = 1'b0;
  logic        rst = 1'b1;
  logic        sync_all = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_ch = '0;
  logic [26:0] cfg_div = '0;
  logic        cfg_mode = 1'b0;
  logic        cfg_en = 1'b1;

  logic       ack_a, err_a, ack_b, err_b;
  logic [3:0] clk_a, tick_a;
  logic [2:0] clk_b, tick_b;

  multi_clk_divider u_dut_a (
    .clk_100mega (clk_100mega),
    .rst         (rst),
    .sync_all    (sync_all),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_div     (cfg_div),
    .cfg_mode    (cfg_mode),
    .cfg_en      (cfg_en),
    .cfg_ack     (ack_a),
    .cfg_err     (err_a),
    .clk_out     (clk_a),
    .tick        (tick_a)
  );

  multi_clk_divider #(.NUM_CH(3), .CNT_W(8), .CH_W(2), .DEFAULT_DIV(5)) u_dut_b (
    .clk_100mega (clk_100mega),
    .rst         (rst),
    .sync_all    (sync_all),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_div     (cfg_div[7:0]),
    .cfg_mode    (cfg_mode),
    .cfg_en      (cfg_en),
    .cfg_ack     (ack_b),
    .cfg_err     (err_b),
    .clk_out     (clk_b),
    .tick        (tick_b)
  );

  always #5 clk_100mega = ~clk_100mega;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a channel's outputs follow from cycles elapsed since its phase origin.
  typedef struct {
    longint div;
    bit     mode;
    bit     en;
    longint sdiv;
    bit     smode;
    bit     sen;
    bit     pend;
    longint start;
    bit     base;
  } mch_t;

  mch_t     m[2][4];
  bit [3:0] e_clk[2];
  bit [3:0] e_tick[2];
  bit       e_ack[2];
  bit       e_err[2];
  longint   now = 0;
  bit       armed = 1'b0;

  function automatic int nch(input int k);
    return (k == 0) ? 4 : 3;
  endfunction

  function automatic longint def_div(input int k);
    return (k == 0) ? 64'd49999 : 64'd5;
  endfunction

  function automatic mch_t take(input mch_t x);
    x.div  = x.sdiv;
    x.mode = x.smode;
    x.en   = x.sen;
    x.pend = 1'b0;
    return x;
  endfunction

  always @(posedge clk_100mega) begin : ref_model
    longint age, q;
    bit lvl;
    now++;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        armed = 1'b1;
        for (int c = 0; c < 4; c++) begin
          m[k][c].div   = def_div(k);
          m[k][c].mode  = 1'b0;
          m[k][c].en    = 1'b1;
          m[k][c].pend  = 1'b0;
          m[k][c].start = now;
          m[k][c].base  = 1'b0;
        end
        e_clk[k] = '0; e_tick[k] = '0; e_ack[k] = 1'b0; e_err[k] = 1'b0;
      end else begin
        for (int c = 0; c < nch(k); c++) begin
          e_clk[k][c]  = 1'b0;
          e_tick[k][c] = 1'b0;
          if (sync_all || !m[k][c].en) begin
            if (m[k][c].pend) m[k][c] = take(m[k][c]);
            m[k][c].start = now;
            m[k][c].base  = 1'b0;
          end else begin
            age = now - m[k][c].start;
            q   = m[k][c].div + 1;
            lvl = m[k][c].base ^ (((age / q) % 2) != 0);
            if (age % q == 0) begin
              e_tick[k][c] = 1'b1;
              e_clk[k][c]  = m[k][c].mode ? 1'b1 : lvl;
              if (m[k][c].pend) begin
                m[k][c]       = take(m[k][c]);
                m[k][c].start = now;
                m[k][c].base  = e_clk[k][c];
              end
            end else begin
              e_clk[k][c] = m[k][c].mode ? 1'b0 : lvl;
            end
          end
          if (cfg_we && int'(cfg_ch) == c) begin
            m[k][c].sdiv  = (k == 0) ? longint'(cfg_div) : longint'(cfg_div[7:0]);
            m[k][c].smode = cfg_mode;
            m[k][c].sen   = cfg_en;
            m[k][c].pend  = 1'b1;
          end
        end
        e_ack[k] = cfg_we && (int'(cfg_ch) < nch(k));
        e_err[k] = cfg_we && (int'(cfg_ch) >= nch(k));
      end
    end
  end

  always @(negedge clk_100mega) begin
    if (armed) begin
      check("clk_out_a", 64'(clk_a),  64'(e_clk[0]));
      check("tick_a",    64'(tick_a), 64'(e_tick[0]));
      check("ack_a",     64'(ack_a),  64'(e_ack[0]));
      check("err_a",     64'(err_a),  64'(e_err[0]));
      check("clk_out_b", 64'(clk_b),  64'(e_clk[1]));
      check("tick_b",    64'(tick_b), 64'(e_tick[1]));
      check("ack_b",     64'(ack_b),  64'(e_ack[1]));
      check("err_b",     64'(err_b),  64'(e_err[1]));
    end
  end

  task automatic wr(input int ch, input int div, input bit mode, input bit en);
    cfg_we   = 1'b1;
    cfg_ch   = 2'(ch);
    cfg_div  = 27'(div);
    cfg_mode = mode;
    cfg_en   = en;
    @(negedge clk_100mega);
    cfg_we   = 1'b0;
  endtask

  task automatic pulse_sync();
    sync_all = 1'b1;
    @(negedge clk_100mega);
    sync_all = 1'b0;
  endtask

  // Cycles until clk_a[idx] next changes level, capped so a stuck output cannot hang the run.
  task automatic wait_change(input int idx, output int n);
    logic prev;
    prev = clk_a[idx];
    n = 0;
    while (n < 200) begin
      @(negedge clk_100mega);
      n++;
      if (clk_a[idx] != prev) break;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk_100mega);
    rst = 1'b0;

    // Default 1 kHz toggle; ch1 rewritten late in the first period.
    n = 0;
    while (n < 49989) begin
      @(negedge clk_100mega);
      n++;
    end
    wr(1, 3, 1'b0, 1'b1);
    n++;
    check("ack_after_write", 64'(ack_a), 64'd1);
    while (n < 60000) begin
      @(negedge clk_100mega);
      n++;
      if (clk_a[0]) break;
    end
    check("first_toggle_cycle", 64'(n), 64'd50000);
    check("ticks_aligned", 64'(tick_a), 64'hf);
    check("all_toggled", 64'(clk_a), 64'hf);
    wait_change(1, n);
    check("ch1_half_period_1", 64'(n), 64'd4);
    wait_change(1, n);
    check("ch1_half_period_2", 64'(n), 64'd4);

    // Pulse mode with div 0: strobe every cycle.
    wr(2, 0, 1'b1, 1'b1);
    pulse_sync();
    check("sync_clears_clk", 64'(clk_a), 64'd0);
    check("sync_clears_tick", 64'(tick_a), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_100mega);
      check("ch2_tick_every_cycle", 64'(tick_a[2]), 64'd1);
      check("ch2_clk_every_cycle", 64'(clk_a[2]), 64'd1);
    end

    // Disable ch3, then re-enable while disabled.
    wr(3, 7, 1'b0, 1'b0);
    pulse_sync();
    repeat (10) @(negedge clk_100mega);
    check("ch3_held_low", 64'(clk_a[3]), 64'd0);
    wr(3, 4, 1'b0, 1'b1);
    n = 0;
    while (n < 200) begin
      @(negedge clk_100mega);
      n++;
      if (clk_a[3]) break;
    end
    check("ch3_first_toggle", 64'(n), 64'd6);

    // Two writes before ch0's wrap: latest wins, single apply.
    wr(0, 6, 1'b0, 1'b1);
    pulse_sync();
    repeat (2) @(negedge clk_100mega);
    wr(0, 9, 1'b0, 1'b1);
    check("ack_first", 64'(ack_a), 64'd1);
    wr(0, 2, 1'b0, 1'b1);
    check("ack_second", 64'(ack_a), 64'd1);
    wait_change(0, n);
    check("ch0_apply_at_wrap", 64'(n), 64'd3);
    wait_change(0, n);
    check("ch0_latest_div", 64'(n), 64'd3);

    // sync_all from differing phases, then sync_all overridden by rst.
    repeat (7) @(negedge clk_100mega);
    pulse_sync();
    check("sync_phase_clk", 64'(clk_a), 64'd0);
    repeat (5) @(negedge clk_100mega);
    wr(1, 8, 1'b0, 1'b1);
    sync_all = 1'b1;
    rst = 1'b1;
    @(negedge clk_100mega);
    check("rst_over_sync_clk", 64'(clk_a), 64'd0);
    check("rst_over_sync_tick", 64'(tick_a), 64'd0);
    sync_all = 1'b0;
    rst = 1'b0;
    repeat (20) @(negedge clk_100mega);
    check("rst_discards_pending", 64'(clk_a[1]), 64'd0);

    // Random traffic, all channels, occasional sync and reset.
    for (int i = 0; i < 3000; i++) begin
      cfg_we   = ($urandom_range(0, 7) == 0);
      cfg_ch   = 2'($urandom_range(0, 3));
      cfg_div  = 27'($urandom_range(0, 12));
      cfg_mode = 1'($urandom_range(0, 1));
      cfg_en   = ($urandom_range(0, 3) != 0);
      sync_all = ($urandom_range(0, 149) == 0);
      rst      = ($urandom_range(0, 699) == 0);
      @(negedge clk_100mega);
    end
    cfg_we = 1'b0;
    sync_all = 1'b0;
    rst = 1'b0;
    repeat (5) @(negedge clk_100mega);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
